// File: rtl/psum_drain.sv
`default_nettype none
// ============================================================================
//  Module      : psum_drain
//  Description : Pops completed psum rows from the corelet output FIFO and
//                writes them to the psum SRAM at consecutive addresses.
//                Accumulate mode reads the row already in SRAM first and adds
//                the FIFO row lane-wise, saturating per lane, before writing.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          system clock, all state on rising edge
//    reset        asynchronous active-low reset
//    start        one-cycle job request, sampled only when idle
//    base_addr    first SRAM address of the job (latched on start)
//    num_rows     rows in the job (latched on start)
//    acc_en       1 = accumulate into SRAM, 0 = overwrite (latched on start)
//    ofifo_valid  OFIFO head row available
//    ofifo_out    OFIFO head row
//    ofifo_rd     OFIFO pop strobe
//    mem_cen      SRAM chip enable, active-low
//    mem_wen      SRAM write enable, active-low
//    mem_addr     SRAM address
//    mem_d        SRAM write data
//    mem_q        SRAM read data, valid the cycle after a read
//    busy         job in progress
//    done         one-cycle completion pulse
// ============================================================================
module psum_drain #(
    parameter int COL     = 8,
    parameter int PSUM_BW = 16,
    parameter int ADDR_BW = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_BW-1:0]       base_addr,
    input  logic [ADDR_BW-1:0]       num_rows,
    input  logic                     acc_en,
    input  logic                     ofifo_valid,
    input  logic [COL*PSUM_BW-1:0]   ofifo_out,
    output logic                     ofifo_rd,
    output logic                     mem_cen,
    output logic                     mem_wen,
    output logic [ADDR_BW-1:0]       mem_addr,
    output logic [COL*PSUM_BW-1:0]   mem_d,
    input  logic [COL*PSUM_BW-1:0]   mem_q,
    output logic                     busy,
    output logic                     done
);

    localparam int c_ROW_W = COL * PSUM_BW;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_POP  = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_ADD  = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]          r_state;
    logic [ADDR_BW-1:0]  r_base;
    logic [ADDR_BW-1:0]  r_num;
    logic                r_acc;
    logic [ADDR_BW-1:0]  r_row_cnt;
    logic [c_ROW_W-1:0]  r_row;
    // Last driven SRAM address/data, so the bus holds between accesses.
    logic [ADDR_BW-1:0]  r_addr_hold;
    logic [c_ROW_W-1:0]  r_d_hold;

    logic [ADDR_BW-1:0]  w_addr;
    logic [c_ROW_W-1:0]  w_sum;
    logic                w_rd_access;
    logic                w_wr_access;

    // Wraps modulo 2^ADDR_BW by construction.
    assign w_addr      = r_base + r_row_cnt;
    assign w_rd_access = (r_state == S_RD);
    assign w_wr_access = (r_state == S_WR);

    // Lane-wise saturating add of the SRAM row and the captured FIFO row.
    // One extra sign bit per lane exposes overflow: if the top two bits of
    // the widened sum differ, clamp toward the sign of the true result.
    for (genvar i = 0; i < COL; i++) begin : g_lane
        logic [PSUM_BW:0] w_ext_sum;
        assign w_ext_sum =
            {mem_q[(i+1)*PSUM_BW-1], mem_q[i*PSUM_BW +: PSUM_BW]} +
            {r_row[(i+1)*PSUM_BW-1], r_row[i*PSUM_BW +: PSUM_BW]};
        assign w_sum[i*PSUM_BW +: PSUM_BW] =
            (w_ext_sum[PSUM_BW] == w_ext_sum[PSUM_BW-1]) ?
                w_ext_sum[PSUM_BW-1:0] :
                {w_ext_sum[PSUM_BW], {(PSUM_BW-1){~w_ext_sum[PSUM_BW]}}};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_num       <= '0;
            r_acc       <= 1'b0;
            r_row_cnt   <= '0;
            r_row       <= '0;
            r_addr_hold <= '0;
            r_d_hold    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base    <= base_addr;
                        r_num     <= num_rows;
                        r_acc     <= acc_en;
                        r_row_cnt <= '0;
                        r_state   <= (num_rows == '0) ? S_DONE : S_POP;
                    end
                end
                S_POP: begin
                    if (ofifo_valid) begin
                        r_row   <= ofifo_out;
                        r_state <= r_acc ? S_RD : S_WR;
                    end
                end
                S_RD: begin
                    r_addr_hold <= w_addr;
                    r_state     <= S_ADD;
                end
                S_ADD: begin
                    r_row   <= w_sum;
                    r_state <= S_WR;
                end
                S_WR: begin
                    r_addr_hold <= w_addr;
                    r_d_hold    <= r_row;
                    if (r_row_cnt == r_num - 1'b1) begin
                        r_state <= S_DONE;
                    end else begin
                        r_row_cnt <= r_row_cnt + 1'b1;
                        r_state   <= S_POP;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Pop only in POP with data present, so an empty FIFO is never popped.
    assign ofifo_rd = (r_state == S_POP) && ofifo_valid;
    assign mem_cen  = ~(w_rd_access | w_wr_access);
    assign mem_wen  = ~w_wr_access;
    assign mem_addr = (w_rd_access | w_wr_access) ? w_addr : r_addr_hold;
    assign mem_d    = w_wr_access ? r_row : r_d_hold;
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_psum_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psum_drain
//  Description : Self-checking bench for psum_drain. Models the OFIFO and the
//                psum SRAM, predicts every SRAM write of a job from the drain
//                rules (overwrite or saturating accumulate), and compares.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_psum_drain;

    localparam int COL     = 8;
    localparam int PSUM_BW = 16;
    localparam int ADDR_BW = 11;
    localparam int ROW_W   = COL * PSUM_BW;
    localparam int DEPTH   = 1 << ADDR_BW;
    localparam int SMAX    = (1 << (PSUM_BW - 1)) - 1;
    localparam int SMIN    = -(1 << (PSUM_BW - 1));

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [ADDR_BW-1:0]  base_addr;
    logic [ADDR_BW-1:0]  num_rows;
    logic                acc_en;
    logic                ofifo_valid;
    logic [ROW_W-1:0]    ofifo_out;
    logic                ofifo_rd;
    logic                mem_cen;
    logic                mem_wen;
    logic [ADDR_BW-1:0]  mem_addr;
    logic [ROW_W-1:0]    mem_d;
    logic [ROW_W-1:0]    mem_q;
    logic                busy;
    logic                done;

    always #5 clk = ~clk;

    psum_drain #(.COL(COL), .PSUM_BW(PSUM_BW), .ADDR_BW(ADDR_BW)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .num_rows    (num_rows),
        .acc_en      (acc_en),
        .ofifo_valid (ofifo_valid),
        .ofifo_out   (ofifo_out),
        .ofifo_rd    (ofifo_rd),
        .mem_cen     (mem_cen),
        .mem_wen     (mem_wen),
        .mem_addr    (mem_addr),
        .mem_d       (mem_d),
        .mem_q       (mem_q),
        .busy        (busy),
        .done        (done)
    );

    // ---------------- OFIFO model (main pushes, environment pops) ----------
    logic [ROW_W-1:0] fifo_mem [0:255];
    logic [7:0]       wr_ptr;
    logic [7:0]       rd_ptr;
    logic             fifo_en;

    assign ofifo_valid = fifo_en && (wr_ptr != rd_ptr);
    assign ofifo_out   = fifo_mem[rd_ptr];

    // ---------------- SRAM model and bus monitor --------------------------
    logic [ROW_W-1:0]   sram    [0:DEPTH-1];
    logic [ROW_W-1:0]   ref_mem [0:DEPTH-1];
    logic [ADDR_BW-1:0] log_addr [0:1023];
    logic [ROW_W-1:0]   log_data [0:1023];
    int wr_cnt, pop_cnt, done_cnt, acc_cnt, bad_cnt;

    logic               pre_en;
    logic [ADDR_BW-1:0] pre_addr;
    logic [ROW_W-1:0]   pre_data;

    logic s_cen, s_wen, s_rd, s_valid, s_busy, s_done;
    logic [ADDR_BW-1:0] s_addr;
    logic [ROW_W-1:0]   s_d;

    function automatic logic [ROW_W-1:0] init_word(input int a);
        logic [ROW_W-1:0] w;
        for (int l = 0; l < COL; l++) w[l*PSUM_BW +: PSUM_BW] = 16'(a * 37 + l * 1031);
        return w;
    endfunction

    // Bus values are sampled mid-cycle and acted on at the following edge.
    always @(negedge clk) begin
        s_cen   = mem_cen;
        s_wen   = mem_wen;
        s_addr  = mem_addr;
        s_d     = mem_d;
        s_rd    = ofifo_rd;
        s_valid = ofifo_valid;
        s_busy  = busy;
        s_done  = done;
    end

    initial begin
        for (int a = 0; a < DEPTH; a++) sram[a] = init_word(a);
        rd_ptr = '0; mem_q = '0;
        wr_cnt = 0; pop_cnt = 0; done_cnt = 0; acc_cnt = 0; bad_cnt = 0;
        forever begin
            @(posedge clk);
            if (pre_en) sram[pre_addr] = pre_data;
            if (s_cen === 1'b0) begin
                acc_cnt++;
                if (s_wen === 1'b0) begin
                    sram[s_addr] = s_d;
                    log_addr[wr_cnt] = s_addr;
                    log_data[wr_cnt] = s_d;
                    wr_cnt++;
                end else begin
                    mem_q <= sram[s_addr];
                end
            end
            if (s_rd === 1'b1) begin
                rd_ptr <= rd_ptr + 8'd1;
                pop_cnt++;
                if (!s_valid || !s_busy || s_done) bad_cnt++;
            end
            if (s_done === 1'b1) done_cnt++;
        end
    end

    // ---------------- checking ---------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [ROW_W-1:0] obs,
                             input logic [ROW_W-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // ---------------- reference model --------------------------------------
    function automatic logic [ROW_W-1:0] sat_acc(input logic [ROW_W-1:0] old_row,
                                                 input logic [ROW_W-1:0] new_row);
        logic [ROW_W-1:0] r;
        for (int l = 0; l < COL; l++) begin
            int s;
            s = int'($signed(old_row[l*PSUM_BW +: PSUM_BW])) +
                int'($signed(new_row[l*PSUM_BW +: PSUM_BW]));
            if (s > SMAX) s = SMAX;
            else if (s < SMIN) s = SMIN;
            r[l*PSUM_BW +: PSUM_BW] = 16'(s);
        end
        return r;
    endfunction

    function automatic logic [ROW_W-1:0] gen_row();
        logic [ROW_W-1:0] r;
        for (int l = 0; l < COL; l++) begin
            case ($urandom_range(0, 3))
                0:       r[l*PSUM_BW +: PSUM_BW] = 16'($urandom);
                1:       r[l*PSUM_BW +: PSUM_BW] = 16'($urandom_range(0, 200));
                2:       r[l*PSUM_BW +: PSUM_BW] = 16'h7F00 + 16'($urandom_range(0, 255));
                default: r[l*PSUM_BW +: PSUM_BW] = 16'h8000 + 16'($urandom_range(0, 255));
            endcase
        end
        return r;
    endfunction

    task automatic push_row(input logic [ROW_W-1:0] r);
        fifo_mem[wr_ptr] = r;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic preload(input logic [ADDR_BW-1:0] a, input logic [ROW_W-1:0] d);
        @(negedge clk);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_en = 1'b0;
        ref_mem[a] = d;
    endtask

    logic [ROW_W-1:0] fixed_q[$];

    // Runs one job and checks pops, writes, done and busy against the model.
    task automatic run_job(input logic [ADDR_BW-1:0] base, input int n, input bit acc,
                           input int stall, input bit start_in_done, input bit use_fixed);
        logic [ROW_W-1:0]   rows[$];
        logic [ADDR_BW-1:0] ea[$];
        logic [ROW_W-1:0]   ed[$];
        logic [ADDR_BW-1:0] a;
        logic [ROW_W-1:0]   r;
        int w0, p0, d0, c0, cyc, waited;
        bit pushed;
        for (int i = 0; i < n; i++) begin
            r = use_fixed ? fixed_q[i] : gen_row();
            rows.push_back(r);
            a = base + ADDR_BW'(i);
            ref_mem[a] = acc ? sat_acc(ref_mem[a], r) : r;
            ea.push_back(a);
            ed.push_back(ref_mem[a]);
        end
        w0 = wr_cnt; p0 = pop_cnt; d0 = done_cnt; c0 = acc_cnt;
        if (stall == 0) foreach (rows[i]) push_row(rows[i]);
        else push_row(rows[0]);
        @(negedge clk);
        start = 1'b1; base_addr = base; num_rows = ADDR_BW'(n); acc_en = acc;
        @(negedge clk);
        start = 1'b0; cyc = 1;
        check_val("busy_after_start", busy, 1'b1);
        waited = 0; pushed = 0;
        while (!done && cyc < 3000) begin
            if (stall > 0 && !pushed && (pop_cnt - p0) >= 1) begin
                waited++;
                if (waited == 4) check_val("stall_wait_pop", {ofifo_rd, mem_cen}, 2'b01);
                if (waited == 3) begin
                    start = 1'b1; base_addr = 11'h300; num_rows = 11'd5; acc_en = ~acc;
                end else begin
                    start = 1'b0;
                end
                if (waited > stall) begin
                    for (int i = 1; i < n; i++) push_row(rows[i]);
                    pushed = 1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (cyc >= 3000) check_val("done_timeout", 1'b0, 1'b1);
        if (stall == 0) check_val("done_latency", cyc, (n == 0) ? 1 : n * (acc ? 4 : 2) + 1);
        if (start_in_done) begin
            start = 1'b1; base_addr = 11'h123; num_rows = 11'd1; acc_en = 1'b0;
            @(negedge clk);
            start = 1'b0;
            check_val("start_in_done_ignored", {busy, done}, 2'b00);
        end else begin
            @(negedge clk);
            check_val("busy_fall", {busy, done}, 2'b00);
        end
        check_val("write_count", wr_cnt - w0, n);
        check_val("pop_count", pop_cnt - p0, n);
        check_val("done_pulses", done_cnt - d0, 1);
        if (n == 0) check_val("no_access_empty_job", acc_cnt - c0, 0);
        for (int i = 0; i < n; i++) begin
            check_val("write_addr", log_addr[w0 + i], ea[i]);
            check_val("write_data", log_data[w0 + i], ed[i]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1);
    end

    logic [ROW_W-1:0] sram_row, fifo_row, want;
    int w0, cyc;

    initial begin
        reset = 1'b0; start = 1'b0; base_addr = '0; num_rows = '0; acc_en = 1'b0;
        wr_ptr = '0; fifo_en = 1'b1; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = init_word(a);
        repeat (3) @(negedge clk);
        check_val("rst_ofifo_rd", ofifo_rd, 1'b0);
        check_val("rst_mem_cen", mem_cen, 1'b1);
        check_val("rst_mem_wen", mem_wen, 1'b1);
        check_val("rst_mem_addr", mem_addr, '0);
        check_val("rst_mem_d", mem_d, '0);
        check_val("rst_busy_done", {busy, done}, 2'b00);
        reset = 1'b1;
        @(negedge clk);

        // Overwrite, lanes 1/2/3
        fixed_q = '{{COL{16'd1}}, {COL{16'd2}}, {COL{16'd3}}};
        run_job(11'h010, 3, 1'b0, 0, 1'b0, 1'b1);
        check_val("ovw_addr0", log_addr[wr_cnt-3], 11'h010);
        check_val("ovw_data2", log_data[wr_cnt-1], {COL{16'd3}});

        // Accumulate 100 + 23
        preload(11'h020, {COL{16'd100}});
        fixed_q = '{{COL{16'd23}}};
        run_job(11'h020, 1, 1'b1, 0, 1'b0, 1'b1);
        check_val("acc_123", log_data[wr_cnt-1], {COL{16'd123}});

        // Saturation in both directions, normal add elsewhere
        sram_row = {{6{16'h1000}}, 16'h8000, 16'h7FF0};
        fifo_row = {{6{16'h0005}}, 16'hFFFF, 16'h0020};
        want     = {{6{16'h1005}}, 16'h8000, 16'h7FFF};
        preload(11'h040, sram_row);
        fixed_q = '{fifo_row};
        run_job(11'h040, 1, 1'b1, 0, 1'b0, 1'b1);
        check_val("sat_row", log_data[wr_cnt-1], want);

        // Stall between rows with an ignored mid-job start
        run_job(11'h100, 2, 1'b0, 5, 1'b0, 1'b0);
        check_val("stall_second_addr", log_addr[wr_cnt-1], 11'h101);
        run_job(11'h180, 3, 1'b1, 5, 1'b0, 1'b0);

        // Empty job, with start pulsed during DONE
        run_job(11'h200, 0, 1'b0, 0, 1'b1, 1'b0);

        // Address wrap
        run_job(11'h7FF, 2, 1'b0, 0, 1'b0, 1'b0);
        check_val("wrap_addr", log_addr[wr_cnt-1], 11'h000);

        // Reset while in RD
        push_row(gen_row());
        w0 = wr_cnt;
        @(negedge clk);
        start = 1'b1; base_addr = 11'h050; num_rows = 11'd1; acc_en = 1'b1;
        @(negedge clk);
        start = 1'b0; cyc = 0;
        while (!(mem_cen == 1'b0 && mem_wen == 1'b1) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_val("reach_rd", (mem_cen == 1'b0 && mem_wen == 1'b1), 1'b1);
        #2 reset = 1'b0;
        #1;
        check_val("midrst_cen_wen", {mem_cen, mem_wen}, 2'b11);
        check_val("midrst_addr", mem_addr, '0);
        check_val("midrst_d", mem_d, '0);
        check_val("midrst_rd_busy_done", {ofifo_rd, busy, done}, 3'b000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("midrst_no_write", wr_cnt - w0, 0);
        run_job(11'h050, 2, 1'b1, 0, 1'b0, 1'b0);

        // Randomized jobs
        for (int j = 0; j < 24; j++) begin
            int n;
            bit acc;
            n   = $urandom_range(0, 6);
            acc = 1'($urandom_range(0, 1));
            run_job(ADDR_BW'($urandom_range(0, DEPTH - 1)), n, acc,
                    (n >= 2 && $urandom_range(0, 2) == 0) ? 5 : 0,
                    1'($urandom_range(0, 1)), 1'b0);
        end

        check_val("no_illegal_pop", bad_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/psum_drain.md
Name: psum_drain

Overview:
- Read-side companion to the corelet output FIFO: pops completed psum rows (col lanes × psum_bw) from the OFIFO and writes them into the psum SRAM at consecutive addresses.
- Optional per-row read-modify-write accumulation against the row already in SRAM, for multi-tile partial-sum reduction.
- Sits between corelet ofifo_output/ofifo_valid and the psum SRAM port. Owns the OFIFO rd strobe (the role inst_q[6] plays at top level).

Parameters:
- col, 8, number of psum lanes per row
- psum_bw, 16, bits per lane (signed two's complement)
- addr_bw, 11, SRAM address width

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low; 0 clears all state immediately
- start  input  1  one-cycle request to begin a drain job; sampled only in IDLE
- base_addr  input  addr_bw  first SRAM address, latched on accepted start
- num_rows  input  addr_bw  rows to drain, latched on accepted start
- acc_en  input  1  1 = accumulate into SRAM contents, 0 = overwrite; latched on start
- ofifo_valid  input  1  OFIFO head row available
- ofifo_out  input  col*psum_bw  OFIFO head row, valid while ofifo_valid=1
- ofifo_rd  output  1  pop strobe, one cycle per row
- mem_cen  output  1  SRAM chip enable, active-low
- mem_wen  output  1  SRAM write enable, active-low (1 = read)
- mem_addr  output  addr_bw  SRAM address
- mem_d  output  col*psum_bw  SRAM write data
- mem_q  input  col*psum_bw  SRAM read data, valid the cycle after a read access
- busy  output  1  high from the cycle after accepted start until DONE exits
- done  output  1  one-cycle pulse at job completion

Behaviour:
- Reset values: ofifo_rd=0, mem_cen=1, mem_wen=1, mem_addr=0, mem_d=0, busy=0, done=0. State=IDLE; row register, row counter and latched config all cleared.
- FSM states:
  - IDLE
    - start=1: latch base_addr, num_rows, acc_en; row_cnt=0.
    - num_rows=0 → DONE; otherwise → POP.
  - POP
    - ofifo_valid=0: wait; ofifo_rd=0; no SRAM access.
    - ofifo_valid=1: ofifo_rd=1 for exactly this cycle; capture ofifo_out into row_reg on the same edge.
    - Next state: RD if acc_en, else WR.
  - RD: mem_cen=0, mem_wen=1, mem_addr=base+row_cnt. → ADD.
  - ADD
    - mem_cen=1 (no access).
    - Lane-wise signed add of mem_q and row_reg, saturating to [-2^(psum_bw-1), 2^(psum_bw-1)-1]; result written back into row_reg.
    - → WR.
  - WR
    - mem_cen=0, mem_wen=0, mem_addr=base+row_cnt, mem_d=row_reg.
    - If row_cnt=num_rows-1 → DONE; else row_cnt+1 → POP.
  - DONE: done=1, busy still 1. → IDLE next cycle.
- Lane i occupies bits [(i+1)*psum_bw-1 : i*psum_bw], the same packing as ofifo_out.
- SRAM signals are driven combinationally from state and registers. Outside RD/WR, mem_cen=1 and mem_wen=1; mem_addr and mem_d hold their last values.
- Address arithmetic wraps modulo 2^addr_bw. base+row_cnt overflowing the address space wraps to 0; no error is raised.
- Throughput:
  - Overwrite mode: 2 cycles/row when the OFIFO never stalls.
  - Accumulate mode: 4 cycles/row.
- Boundary conditions:
  - start while busy: ignored; latched config is unchanged.
  - start during DONE: ignored. A start asserted in the IDLE cycle after DONE is accepted.
  - ofifo_valid dropping mid-job: FSM holds in POP indefinitely; no timeout.
  - ofifo_rd is never asserted in IDLE or DONE, nor when ofifo_valid=0. Popping an empty OFIFO is prohibited.
  - Reset asserted mid-job: all outputs return to reset values asynchronously. The in-flight row is discarded; the SRAM write of a partially processed row is not completed.

Test Plan:
- Overwrite: base=0x010, num_rows=3, acc_en=0; OFIFO preloaded with rows whose every lane = 1, 2, 3 → three pops; writes at 0x010/0x011/0x012 with lanes 1/2/3; done pulses 6 cycles after the first POP; busy falls the cycle after done.
- Accumulate: SRAM[0x020] lanes = 100, OFIFO row lanes = 23, acc_en=1, num_rows=1 → read at 0x020, then write 123 to all lanes; exactly one ofifo_rd.
- Saturation: SRAM lane = 0x7FF0 and row lane = 0x0020 → 0x7FFF. SRAM lane = 0x8000 and row lane = 0xFFFF → 0x8000. Other lanes add normally.
- Stall/ignored start:
  - Stimulus: num_rows=2; ofifo_valid low for 5 cycles between the two rows; pulse start mid-job with base=0x300.
  - Required response: FSM waits in POP with ofifo_rd=0; second write still at base+1 of the original base; done pulses once.
- Edge cases:
  - num_rows=0 → done one cycle after start, no ofifo_rd, no SRAM access.
  - base=0x7FF, num_rows=2 → writes at 0x7FF then 0x000.
- Reset mid-job: drive reset=0 while in RD → outputs go to reset values within the same cycle; after release, a new start runs a clean job from row 0.
